// File: rtl/bcd_to_bin_loader_if.sv
// Digit entry / result bus for bcd_to_bin_loader.
//   dig_in[3:0], dig_valid, dig_clr : digit stream from the producer
//   dig_ready                        : loader can take a digit this cycle
//   bin_out[W-1:0]                   : last assembled binary value (held)
//   bin_valid, err                   : one-cycle result pulses
//   busy                             : loader is mid-entry
interface bcd_to_bin_loader_if #(
   parameter int unsigned W = 6
);
   logic [3:0]   dig_in;
   logic         dig_valid;
   logic         dig_clr;
   logic         dig_ready;
   logic [W-1:0] bin_out;
   logic         bin_valid;
   logic         err;
   logic         busy;

   // Producer side of the bus
   modport master (
      output dig_in, dig_valid, dig_clr,
      input  dig_ready, bin_out, bin_valid, err, busy
   );

   // Loader side of the bus
   modport slave (
      input  dig_in, dig_valid, dig_clr,
      output dig_ready, bin_out, bin_valid, err, busy
   );
endinterface

// File: rtl/bcd_to_bin_loader.sv
// Assembles a two-digit BCD entry (tens then ones) into a binary value
// bounded by MAX_VAL. Illegal tens digits are rejected at once; the full
// value is range-checked in a one-cycle CHECK state, and bin_valid or err
// is pulsed in the cycle after CHECK.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of bcd_to_bin_loader_if (digits in, result out)
module bcd_to_bin_loader #(
   parameter int unsigned MAX_VAL = 59,
   parameter int unsigned W       = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   bcd_to_bin_loader_if.slave  bus
);

   localparam int unsigned SUM_W = 7;
   localparam logic [3:0]       TENS_MAX = 4'(MAX_VAL / 10);
   localparam logic [SUM_W-1:0] SUM_MAX  = SUM_W'(MAX_VAL);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_ONES = 2'b01,
      CHECK     = 2'b10
   } state_e;

   state_e         state_q, state_d;
   logic [3:0]     tens_q, tens_d;
   logic [3:0]     ones_q, ones_d;
   logic [W-1:0]   bin_out_q, bin_out_d;
   logic           bin_valid_q, bin_valid_d;
   logic           err_q, err_d;
   logic           dig_ready_q, dig_ready_d;
   logic           busy_q, busy_d;
   logic           accept;
   logic [SUM_W-1:0] sum;

   // ready is a registered copy of (state != CHECK), so it gates acceptance directly
   assign accept = bus.dig_valid && dig_ready_q;

   // tens*10 + ones as (tens<<3)+(tens<<1)+ones; max 9*10+15 fits in 7 bits
   assign sum = (SUM_W'(tens_q) << 3) + (SUM_W'(tens_q) << 1) + SUM_W'(ones_q);

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      bin_out_d   = bin_out_q;
      bin_valid_d = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (!bus.dig_clr && accept) begin
               if ((bus.dig_in > 4'd9) || (bus.dig_in > TENS_MAX)) begin
                  err_d = 1'b1;
               end else begin
                  tens_d  = bus.dig_in;
                  state_d = WAIT_ONES;
               end
            end
         end
         WAIT_ONES: begin
            if (bus.dig_clr) begin
               state_d = IDLE;
            end else if (accept) begin
               ones_d  = bus.dig_in;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // dig_clr is deliberately ignored here: the entry always completes
            state_d = IDLE;
            if ((ones_q <= 4'd9) && (sum <= SUM_MAX)) begin
               bin_out_d   = W'(sum);
               bin_valid_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      dig_ready_d = (state_d != CHECK);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tens_q      <= 4'd0;
         ones_q      <= 4'd0;
         bin_out_q   <= '0;
         bin_valid_q <= 1'b0;
         err_q       <= 1'b0;
         dig_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         bin_out_q   <= bin_out_d;
         bin_valid_q <= bin_valid_d;
         err_q       <= err_d;
         dig_ready_q <= dig_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.dig_ready = dig_ready_q;
   assign bus.bin_out   = bin_out_q;
   assign bus.bin_valid = bin_valid_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;

endmodule
